csa_accum_ctrl: RTL and testbench

Sequencing controller that time-multiplexes one `carry_save_adder` (N buses of W bits, E extension bits) over a multi-beat operand stream. Each job is `beats` words, each W*N bits wide. The block accumulates the per-word sums into a wide binary total and presents it on a valid/ready result port. It sits between the operand buffers and the layer accumulator in the CNN datapath.

---
 rtl/csa_accum_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_csa_accum_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: multi-beat carry-save accumulation controller.
// One carry_save_adder is reused across the beats of a job. Each beat's
// {sum, cout} is registered (S1) and then folded into a wide binary
// accumulator (S2). The job total is then offered on a valid/ready port.
//
// Build option: define CSA_IN_REG_EN to register in_data (S0) before the CSA.
// This adds one cycle of latency. Handshakes and results do not change.
//
// state | meaning
// IDLE  | waiting for start; an illegal beat count pulses err
// ACCUM | accepting operand beats until remaining reaches zero
// DRAIN | last beat taken; waiting for the pipeline valid bits to clear
// DONE  | result presented on out_sum until out_ready handshake

module carry_save_adder #(
    parameter int N = 17,
    parameter int E = 4,
    parameter int W = 3
) (
    input  logic [W*N-1:0] data,
    output logic [W+E-1:0] sum,
    output logic [W+E-1:0] cout
);
    logic [W+E-1:0] s_acc;
    logic [W+E-1:0] c_acc;
    logic [W+E-1:0] x_ext;
    logic [W+E-1:0] maj;

    // Chain of 3:2 compressors. sum + cout equals the bus total modulo
    // 2^(W+E). The total is exact because N*(2^W-1) < 2^(W+E).
    always_comb begin
        s_acc = '0;
        c_acc = '0;
        x_ext = '0;
        maj   = '0;
        for (int i = 0; i < N; i++) begin
            x_ext = {{E{1'b0}}, data[i*W +: W]};
            maj   = (s_acc & c_acc) | (s_acc & x_ext) | (c_acc & x_ext);
            s_acc = s_acc ^ c_acc ^ x_ext;
            c_acc = maj << 1;
        end
        sum  = s_acc;
        cout = c_acc;
    end
endmodule

module csa_accum_ctrl #(
    parameter int N     = 17,
    parameter int E     = 4,
    parameter int W     = 3,
    parameter int K_MAX = 16,
    parameter int CW    = $clog2(K_MAX + 1),
    parameter int AW    = W + E + $clog2(K_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] beats,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W*N-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic          busy,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    localparam int SW = W + E;
    localparam logic [CW-1:0] K_MAX_C = CW'(K_MAX);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t        state;
    logic [CW-1:0] remaining;
    logic [AW-1:0] acc;
    logic          accept;
    logic          beats_legal;
    logic          start_ok;
    logic          start_bad;
    logic          pipe_busy;
    logic          s1_load;
    logic [W*N-1:0] csa_data;
    logic [SW-1:0] csa_sum;
    logic [SW-1:0] csa_cout;
    logic [SW-1:0] s1_sum;
    logic [SW-1:0] s1_cout;
    logic [SW-1:0] s1_total;
    logic          s1_valid;
    logic          s2_valid;

    // in_ready is only ever high in ACCUM, so it also gates in_valid by state.
    assign accept      = in_valid && in_ready;
    assign beats_legal = (beats != '0) && (beats <= K_MAX_C);
    assign start_ok    = (state == IDLE) && start && beats_legal;
    assign start_bad   = (state == IDLE) && start && !beats_legal;

`ifdef CSA_IN_REG_EN
    logic [W*N-1:0] s0_data;
    logic           s0_valid;

    // S0: capture each accepted operand word ahead of the CSA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_data  <= '0;
            s0_valid <= 1'b0;
        end else begin
            s0_valid <= accept;
            if (accept) s0_data <= in_data;
        end
    end

    assign csa_data  = s0_data;
    assign s1_load   = s0_valid;
    assign pipe_busy = s0_valid || s1_valid || s2_valid;
`else
    assign csa_data  = in_data;
    assign s1_load   = accept;
    assign pipe_busy = s1_valid || s2_valid;
`endif

    carry_save_adder #(.N(N), .E(E), .W(W)) u_csa (
        .data (csa_data),
        .sum  (csa_sum),
        .cout (csa_cout)
    );

    // S1: register the redundant CSA result together with its valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum   <= '0;
            s1_cout  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= s1_load;
            if (s1_load) begin
                s1_sum  <= csa_sum;
                s1_cout <= csa_cout;
            end
        end
    end

    // The add is done at W+E bits. The wrap of the redundant pair then cancels.
    assign s1_total = s1_sum + s1_cout;

    // S2: fold the beat total into the accumulator. It is cleared on a new job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (start_ok)      acc <= '0;
            else if (s1_valid) acc <= acc + AW'(s1_total);
        end
    end

    // Sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= start_bad;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        remaining <= beats;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        remaining <= remaining - ONE_C;
                        if (remaining == ONE_C) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        out_valid <= 1'b1;
                        out_sum   <= acc;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed and randomized bench for csa_accum_ctrl (default parameters).
module tb_csa_accum_ctrl;
    localparam int N = 17;
    localparam int W = 3;
    localparam int CW = 5;
    localparam int AW = 11;
    localparam int DW = 51;
`ifdef CSA_IN_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        int             b;
        logic [DW-1:0]  d;
        int             exp_sum;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] beats = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_sum;
    logic          busy;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    csa_accum_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .beats     (beats),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int bus_sum(input logic [DW-1:0] d);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(d[i*W +: W]);
        return s;
    endfunction

    // vmode: 0 in_valid held high, 1 toggling 1,0,1,..., 2 random valid and data
    task automatic run_job(input int b, input logic [DW-1:0] d, input int vmode,
                           input int stall, output int sum, output int lat,
                           output int seq_ok, output int ref_total);
        int n_acc = 0;
        int guard = 0;
        bit tog = 1'b1;
        logic [63:0] r;
        seq_ok = 1;
        ref_total = 0;
        start = 1'b1;
        beats = CW'(b);
        @(negedge clk);
        start = 1'b0;
        if (!busy || !in_ready) seq_ok = 0;
        while (n_acc < b && guard < 200) begin
            case (vmode)
                0: in_valid = 1'b1;
                1: begin in_valid = tog; tog = ~tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (vmode == 2) begin
                r = {$urandom(), $urandom()};
                in_data = r[DW-1:0];
            end else begin
                in_data = d;
            end
            if (in_ready && in_valid) begin
                n_acc++;
                ref_total += bus_sum(in_data);
            end
            if (!busy) seq_ok = 0;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        in_data = '0;
        chk("beats_accepted", n_acc, b);
        lat = 0;
        out_ready = (stall == 0);
        while (!out_valid && lat < 20) begin
            if (in_ready || !busy) seq_ok = 0;
            @(negedge clk);
            lat++;
        end
        sum = int'(out_sum);
        for (int i = 0; i < stall; i++) begin
            start = (i == 0);
            beats = '0;
            @(negedge clk);
            start = 1'b0;
            if (!out_valid || int'(out_sum) != sum || in_ready || !busy || err) seq_ok = 0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_handshake", {out_valid, busy, in_ready}, 0);
    endtask

    initial begin
        vec_t tbl[5];
        logic [55:0] pat56;
        logic [DW-1:0] pat;
        logic [DW-1:0] ones;
        int sum, lat, ok, rt;

        ones = '1;
        pat56 = {7{8'hEC}};
        pat = pat56[DW-1:0];

        tbl[0] = '{4,  ones,             476};
        tbl[1] = '{16, ones,             1904};
        tbl[2] = '{1,  '0,               0};
        tbl[3] = '{2,  {3'b111, 48'h0},  14};
        tbl[4] = '{3,  pat,              222};

        // reset values
        @(negedge clk);
        chk("reset_outputs", {in_ready, out_valid, busy, err, out_sum}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_outputs", {in_ready, out_valid, busy, err, out_sum}, 0);

        for (int k = 0; k < 5; k++) begin
            run_job(tbl[k].b, tbl[k].d, 0, 0, sum, lat, ok, rt);
            chk($sformatf("vec%0d_sum", k), sum, tbl[k].exp_sum);
            chk($sformatf("vec%0d_latency", k), lat, LAT);
            chk($sformatf("vec%0d_sequence", k), ok, 1);
        end

        // bubbles and a 5-cycle result stall, with an ignored start in DONE
        run_job(3, pat, 1, 5, sum, lat, ok, rt);
        chk("bubble_sum", sum, 222);
        chk("bubble_latency", lat, LAT);
        chk("bubble_stall_sequence", ok, 1);

        // illegal starts
        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            beats = (k == 0) ? 5'd0 : 5'd17;
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("illegal%0d_err", k), err, 1);
            chk($sformatf("illegal%0d_busy", k), {busy, in_ready}, 0);
            @(negedge clk);
            chk($sformatf("illegal%0d_err_single", k), err, 0);
        end
        run_job(1, ones, 0, 0, sum, lat, ok, rt);
        chk("post_illegal_sum", sum, 119);

        // reset after 2 of 8 beats
        start = 1'b1;
        beats = 5'd8;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        in_data = ones;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midjob_reset_outputs", {in_ready, out_valid, busy, err, out_sum}, 0);
        @(negedge clk);
        chk("midjob_reset_held", {in_ready, out_valid, busy, err, out_sum}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_job(1, ones, 0, 0, sum, lat, ok, rt);
        chk("post_reset_sum", sum, 119);
        chk("post_reset_latency", lat, LAT);

        // randomized jobs
        for (int j = 0; j < 60; j++) begin
            run_job(int'($urandom_range(1, 16)), '0, 2, int'($urandom_range(0, 3)),
                    sum, lat, ok, rt);
            chk($sformatf("rand%0d_sum", j), sum, rt);
            chk($sformatf("rand%0d_sequence", j), ok, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
